aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller that time-shares one external round datapath across all ten rounds of a block. It accepts a 128-bit plaintext on a valid/ready port and fetches round keys by index from an external key store. It applies the initial whitening XOR itself, then drives the shared round unit once per round, flagging the final round so the datapath skips MixColumns. The ciphertext is presented on a valid/ready output port. It sits between the block-level stream interface and the table-lookup round datapath.

---
 rtl/aes_seq_pkg.sv | 15 +
 rtl/aes_round_sequencer_if.sv | 34 +++
 rtl/aes_seq_wait_timer.sv | 29 ++
 rtl/aes_round_sequencer.sv | 126 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
package aes_seq_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int KEY_IDX_W     = 4;
    localparam int BLOCK_W       = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Plaintext/ciphertext streams, key-store lookup and shared round-unit port.
interface aes_round_sequencer_if;
    import aes_seq_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [BLOCK_W-1:0]   in_data;
    logic [KEY_IDX_W-1:0] key_idx;
    logic [BLOCK_W-1:0]   key_in;
    logic                 rd_start;
    logic [BLOCK_W-1:0]   rd_state;
    logic [BLOCK_W-1:0]   rd_key;
    logic                 rd_final;
    logic [BLOCK_W-1:0]   rd_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [BLOCK_W-1:0]   out_data;
    logic                 busy;

    // Sequencer side.
    modport master (
        input  in_valid, in_data, key_in, rd_result, out_ready,
        output in_ready, key_idx, rd_start, rd_state, rd_key, rd_final,
               out_valid, out_data, busy
    );

    // Stream source/sink, key store and round datapath side.
    modport slave (
        output in_valid, in_data, key_in, rd_result, out_ready,
        input  in_ready, key_idx, rd_start, rd_state, rd_key, rd_final,
               out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_seq_wait_timer.sv
// Loadable down-counter that times the fixed round-datapath latency.
module aes_seq_wait_timer #(
    parameter int ROUND_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_expired
);

    localparam int CNT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ROUND_LAT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Load on issue, then count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller sharing one external round datapath.
//
// state | meaning
// IDLE  | accept plaintext, whiten with key 0
// ISSUE | one-cycle rd_start for the current round
// WAIT  | wait for the datapath result, then capture it
// DONE  | hold ciphertext until the consumer takes it
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int ROUNDS    = AES128_ROUNDS,
    parameter int ROUND_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_sequencer_if.master bus
);

    localparam logic [KEY_IDX_W-1:0] LAST_ROUND = KEY_IDX_W'(ROUNDS);

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    logic [BLOCK_W-1:0]   r_state_reg;
    logic [BLOCK_W-1:0]   r_rd_key;
    logic [KEY_IDX_W-1:0] r_round;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_last;
    logic                 w_timer_load;
    logic                 w_timer_expired;

    assign w_last = (r_round == LAST_ROUND);

    aes_seq_wait_timer #(
        .ROUND_LAT (ROUND_LAT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_timer_load),
        .o_expired (w_timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/datapath control outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_timer_load  = 1'b0;
        bus.in_ready  = 1'b0;
        bus.key_idx   = r_round;
        bus.rd_start  = 1'b0;
        bus.rd_key    = r_rd_key;
        bus.rd_final  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.key_idx  = '0;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Key register loads at the end of this cycle, so pass the
                // key store straight through while issuing.
                bus.rd_start = 1'b1;
                bus.rd_key   = bus.key_in;
                bus.rd_final = w_last;
                w_timer_load = 1'b1;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                bus.rd_final = w_last;
                if (w_timer_expired) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_last ? DONE : ISSUE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Block state, held round key and round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_reg <= '0;
            r_rd_key    <= '0;
            r_round     <= '0;
        end else begin
            if (w_accept) begin
                r_state_reg <= bus.in_data ^ bus.key_in;
                r_round     <= KEY_IDX_W'(1);
            end else if (w_capture) begin
                r_state_reg <= bus.rd_result;
                if (!w_last) begin
                    r_round <= r_round + 1'b1;
                end
            end
            if (r_state == ISSUE) begin
                r_rd_key <= bus.key_in;
            end
        end
    end

    assign bus.rd_state = r_state_reg;
    assign bus.out_data = r_state_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: three instances at round latencies 1, 2, 4,
// each with a key store and an AES round datapath model.
module tb_aes_round_sequencer;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DP_JUNK  = 128'hdeadbeef_0badf00d_5a5a5a5a_c3c3c3c3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [16];

    logic         in_valid    [3];
    logic [127:0] in_data     [3];
    logic         out_ready   [3];
    logic         o_in_ready  [3];
    logic         o_busy      [3];
    logic         o_rd_start  [3];
    logic         o_rd_final  [3];
    logic         o_out_valid [3];
    logic [3:0]   o_key_idx   [3];
    logic [127:0] o_out_data  [3];
    logic [127:0] o_rd_key    [3];

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                t[4*c+w] = b[4*((c+w)%4)+w];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
        return s;
    endfunction

    function automatic int lat_of(input int ii);
        return (ii == 0) ? 1 : ((ii == 1) ? 2 : 4);
    endfunction

    task automatic build_tables(input logic [127:0] key);
        logic [7:0]  inv;
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

        aes_round_sequencer_if bus ();

        aes_round_sequencer #(
            .ROUNDS    (10),
            .ROUND_LAT (LAT)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.master)
        );

        logic [127:0] dp_val;
        int           dp_cnt;

        // Key store output is scrambled outside accept/issue cycles.
        assign bus.key_in    = (bus.in_ready || bus.rd_start) ? rk[bus.key_idx] : ~rk[bus.key_idx];
        assign bus.in_valid  = in_valid[gi];
        assign bus.in_data   = in_data[gi];
        assign bus.out_ready = out_ready[gi];
        assign bus.rd_result = (dp_cnt == LAT) ? dp_val : DP_JUNK;

        assign o_in_ready[gi]  = bus.in_ready;
        assign o_busy[gi]      = bus.busy;
        assign o_rd_start[gi]  = bus.rd_start;
        assign o_rd_final[gi]  = bus.rd_final;
        assign o_out_valid[gi] = bus.out_valid;
        assign o_key_idx[gi]   = bus.key_idx;
        assign o_out_data[gi]  = bus.out_data;
        assign o_rd_key[gi]    = bus.rd_key;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dp_cnt <= 0;
            end else if (bus.rd_start) begin
                dp_cnt <= 1;
                dp_val <= aes_round(bus.rd_state, bus.rd_key, bus.rd_final);
            end else if (dp_cnt == LAT) begin
                dp_cnt <= 0;
            end else if (dp_cnt != 0) begin
                dp_cnt <= dp_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input int ii, input string tag);
        check_eq({tag, "_in_ready"},  128'(o_in_ready[ii]),  128'd1);
        check_eq({tag, "_busy"},      128'(o_busy[ii]),      128'd0);
        check_eq({tag, "_rd_start"},  128'(o_rd_start[ii]),  128'd0);
        check_eq({tag, "_rd_final"},  128'(o_rd_final[ii]),  128'd0);
        check_eq({tag, "_out_valid"}, 128'(o_out_valid[ii]), 128'd0);
        check_eq({tag, "_key_idx"},   128'(o_key_idx[ii]),   128'd0);
        check_eq({tag, "_out_data"},  o_out_data[ii],        128'd0);
        check_eq({tag, "_rd_key"},    o_rd_key[ii],          128'd0);
    endtask

    // Entered and left mid-cycle (after a falling edge).
    task automatic run_block(input int ii, input logic [127:0] pt, input logic [127:0] exp_ct,
                             input int hold, input bit junk, input bit ready_hi,
                             input string tag, output int acc_wait);
        int lat, n_st, done_c, exp_c;
        int bad_sp, bad_fin, bad_key, bad_busy, bad_hold;
        lat = lat_of(ii);
        n_st = 0; done_c = -1; acc_wait = 0;
        bad_sp = 0; bad_fin = 0; bad_key = 0; bad_busy = 0; bad_hold = 0;
        in_valid[ii]  = 1'b1;
        in_data[ii]   = pt;
        out_ready[ii] = ready_hi;
        while (!o_in_ready[ii] && acc_wait < 50) begin
            @(negedge clk);
            acc_wait++;
        end
        if (!o_in_ready[ii]) begin
            check_eq({tag, "_accept_timeout"}, 128'd0, 128'd1);
            in_valid[ii] = 1'b0;
            return;
        end
        check_eq({tag, "_kidx_accept"}, 128'(o_key_idx[ii]), 128'd0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (junk) begin
                in_valid[ii] = c[0];
                in_data[ii]  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid[ii] = 1'b0;
            end
            if (o_in_ready[ii] || !o_busy[ii]) bad_busy++;
            if (o_rd_start[ii]) begin
                exp_c = 1 + n_st * (lat + 1);
                if (c != exp_c) bad_sp++;
                if (o_rd_final[ii] != (n_st == 9)) bad_fin++;
                if (o_key_idx[ii] != 4'(n_st + 1)) bad_key++;
                n_st++;
            end
            if (o_out_valid[ii]) begin
                done_c = c;
                break;
            end
        end
        in_valid[ii] = 1'b0;
        check_eq({tag, "_starts"},     128'(n_st),     128'd10);
        check_eq({tag, "_spacing"},    128'(bad_sp),   128'd0);
        check_eq({tag, "_final"},      128'(bad_fin),  128'd0);
        check_eq({tag, "_key_seq"},    128'(bad_key),  128'd0);
        check_eq({tag, "_busy"},       128'(bad_busy), 128'd0);
        check_eq({tag, "_done_cycle"}, 128'(done_c),   128'(10 * (lat + 1) + 1));
        check_eq({tag, "_ct"},         o_out_data[ii], exp_ct);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (o_out_data[ii] !== exp_ct || !o_out_valid[ii] || o_in_ready[ii]) bad_hold++;
        end
        if (hold > 0) check_eq({tag, "_hold"}, 128'(bad_hold), 128'd0);
        out_ready[ii] = 1'b1;
        @(negedge clk);
        check_eq({tag, "_idle_ready"}, 128'(o_in_ready[ii]),  128'd1);
        check_eq({tag, "_idle_valid"}, 128'(o_out_valid[ii]), 128'd0);
        out_ready[ii] = ready_hi;
    endtask

    initial begin
        logic [127:0] pt;
        int           w;
        int           n;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = 128'h0;
            out_ready[i] = 1'b0;
        end
        build_tables(FIPS_KEY);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle_outputs(i, $sformatf("reset%0d", i));
        rst_n = 1'b1;
        @(negedge clk);

        run_block(1, FIPS_PT, FIPS_CT, 20, 1'b0, 1'b0, "fips_l2_bp", w);
        run_block(0, FIPS_PT, FIPS_CT, 0,  1'b0, 1'b0, "fips_l1", w);
        run_block(2, FIPS_PT, FIPS_CT, 0,  1'b0, 1'b0, "fips_l4", w);

        pt = 128'h3243f6a8885a308d313198a2e0370734;
        run_block(1, pt, aes_ref(pt), 0, 1'b1, 1'b0, "junk_in_wait", w);

        pt = 128'hffeeddccbbaa99887766554433221100;
        in_valid[1] = 1'b1;
        in_data[1]  = pt;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            in_valid[1] = 1'b0;
            if (o_rd_start[1]) n++;
            if (n == 5) break;
        end
        check_eq("rst_reach_round5", 128'(n), 128'd5);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(1, "midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_block(1, pt, aes_ref(pt), 0, 1'b0, 1'b0, "after_rst", w);

        pt = 128'h0123456789abcdeffedcba9876543210;
        run_block(1, pt, aes_ref(pt), 0, 1'b0, 1'b1, "b2b_a", w);
        pt = 128'h00000000000000000000000000000001;
        run_block(1, pt, aes_ref(pt), 0, 1'b0, 1'b1, "b2b_b", w);
        check_eq("b2b_accept_gap", 128'(w), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
